// File: rtl/voting_if.sv
// Voter-side bus of voting_session_ctrl: session control, ballot requests/grants and result.
interface voting_if #(
  parameter int NUM_VOTERS = 8
);
  logic                    start;
  logic                    close;
  logic [NUM_VOTERS-1:0]   req;
  logic [2*NUM_VOTERS-1:0] ballot;
  logic [NUM_VOTERS-1:0]   gnt;
  logic                    busy;
  logic                    done;
  logic [1:0]              winner;
  logic                    tie;
  logic [11:0]             tally;

  modport master (
    output start, close, req, ballot,
    input  gnt, busy, done, winner, tie, tally
  );

  modport slave (
    input  start, close, req, ballot,
    output gnt, busy, done, winner, tie, tally
  );
endinterface

// File: rtl/voting_session_ctrl.sv
// Voting session controller: round-robin ballot collection, 3-candidate tally, winner decision.
// Optional macro VOTE_TIMEOUT_EN adds a COLLECT cycle limit of TIMEOUT_CYCLES.
module voting_session_ctrl #(
  parameter int NUM_VOTERS     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic     clk,
  input logic     rst,
  voting_if.slave bus
);
  localparam int PW = 3;

  typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, DONE} state_t;

  state_t                  state;
  logic [NUM_VOTERS-1:0]   voted;
  logic [NUM_VOTERS-1:0]   gnt;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gidx;
  logic                    gvalid;
  logic [1:0]              gballot;
  logic [3:0]              ta, tb, tc;
  logic                    busy_q, done_q, tie_q;
  logic [1:0]              winner_q;
  logic                    all_voted;
  logic                    timeout;
  logic [1:0]              win_c;
  logic                    tie_c;
  logic [3:0]              mx;

  // Scan offsets from the pointer; the inner loop maps the wrapped offset to a fixed index.
  always_comb begin
    int unsigned ofs;
    gnt     = '0;
    gidx    = '0;
    gvalid  = 1'b0;
    gballot = '0;
    ofs     = 0;
    if (state == COLLECT) begin
      for (int unsigned k = 0; k < NUM_VOTERS; k++) begin
        ofs = 32'(ptr) + k;
        if (ofs >= NUM_VOTERS) ofs = ofs - NUM_VOTERS;
        for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
          if (!gvalid && (i == ofs) && bus.req[i] && !voted[i]) begin
            gvalid  = 1'b1;
            gnt[i]  = 1'b1;
            gidx    = PW'(i);
            gballot = bus.ballot[2*i +: 2];
          end
        end
      end
    end
  end

  assign all_voted = &(voted | gnt);

  always_comb begin
    mx = ta;
    if (tb > mx) mx = tb;
    if (tc > mx) mx = tc;
    win_c = 2'd0;
    tie_c = 1'b0;
    if (mx != 4'd0) begin
      if (ta == mx)      win_c = 2'd1;
      else if (tb == mx) win_c = 2'd2;
      else               win_c = 2'd3;
      tie_c = ((ta == mx) && (tb == mx)) || ((ta == mx) && (tc == mx)) ||
              ((tb == mx) && (tc == mx));
    end
  end

`ifdef VOTE_TIMEOUT_EN
  logic [15:0] tcnt;
  assign timeout = (state == COLLECT) && (tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      voted    <= '0;
      ptr      <= '0;
      ta       <= '0;
      tb       <= '0;
      tc       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      winner_q <= '0;
      tie_q    <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= COLLECT;
            voted    <= '0;
            ptr      <= '0;
            ta       <= '0;
            tb       <= '0;
            tc       <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            busy_q   <= 1'b1;
`ifdef VOTE_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end
        end
        COLLECT: begin
          if (gvalid) begin
            voted <= voted | gnt;
            ptr   <= (gidx == PW'(NUM_VOTERS - 1)) ? '0 : gidx + 1'b1;
            case (gballot)
              2'd1:    if (ta != 4'hF) ta <= ta + 4'd1;
              2'd2:    if (tb != 4'hF) tb <= tb + 4'd1;
              2'd3:    if (tc != 4'hF) tc <= tc + 4'd1;
              default: ;
            endcase
          end
`ifdef VOTE_TIMEOUT_EN
          tcnt <= tcnt + 16'd1;
`endif
          if (all_voted || bus.close || timeout) state <= DECIDE;
        end
        DECIDE: begin
          winner_q <= win_c;
          tie_q    <= tie_c;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state    <= DONE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.winner = winner_q;
  assign bus.tie    = tie_q;
  assign bus.tally  = {tc, tb, ta};
endmodule
